// File: rtl/instr_dispatch.sv
// In-order instruction dispatch buffer: a small FIFO whose head is steered to the
// ALU, SFU or vector port by opcode class; illegal opcodes are retired and counted.
module instr_dispatch #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [39:0]                  in_instr,
  output logic                         alu_valid,
  input  logic                         alu_ready,
  output logic [39:0]                  alu_instr,
  output logic                         sfu_valid,
  input  logic                         sfu_ready,
  output logic [39:0]                  sfu_instr,
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic [39:0]                  vec_instr,
  output logic                         illegal_valid,
  output logic [7:0]                   illegal_op,
  output logic [CNT_W-1:0]             illegal_count,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_SFU = 2'd1,
    CLS_VEC = 2'd2,
    CLS_ILL = 2'd3
  } op_class_t;

  function automatic op_class_t classify_op(input logic [7:0] op);
    op_class_t cls;
    if (op <= 8'd9) begin
      cls = CLS_ALU;
    end else if (op <= 8'd14) begin
      cls = CLS_SFU;
    end else if (op <= 8'd16) begin
      cls = CLS_ALU;
    end else if (op <= 8'd20) begin
      cls = CLS_VEC;
    end else begin
      cls = CLS_ILL;
    end
    return cls;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic [39:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] count_r;
  logic             illegal_valid_r;
  logic [7:0]       illegal_op_r;
  logic [CNT_W-1:0] illegal_count_r;

  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             ill_pop_s;
  logic [39:0]      head_s;
  op_class_t        head_cls_s;

  // Head decode and FIFO status from registered state only.
  always_comb begin
    empty_s    = (count_r == {OCC_W{1'b0}});
    full_s     = (count_r == OCC_W'(DEPTH));
    head_s     = mem_r[rd_ptr_r];
    head_cls_s = classify_op(head_s[39:32]);
  end

  // Port steering: valids never look at any *_ready input.
  always_comb begin
    alu_valid = 1'b0;
    sfu_valid = 1'b0;
    vec_valid = 1'b0;
    ill_pop_s = 1'b0;
    if (!empty_s) begin
      case (head_cls_s)
        CLS_ALU: alu_valid = 1'b1;
        CLS_SFU: sfu_valid = 1'b1;
        CLS_VEC: vec_valid = 1'b1;
        CLS_ILL: ill_pop_s = 1'b1;
        default: ill_pop_s = 1'b1;
      endcase
    end else begin
      ill_pop_s = 1'b0;
    end
  end

  // Handshake qualification and output buses.
  always_comb begin
    push_s    = in_valid && !full_s;
    pop_s     = (alu_valid && alu_ready) || (sfu_valid && sfu_ready) ||
                (vec_valid && vec_ready) || ill_pop_s;
    in_ready  = !full_s;
    idle      = empty_s;
    occupancy = count_r;
    if (empty_s) begin
      alu_instr = 40'h0;
      sfu_instr = 40'h0;
      vec_instr = 40'h0;
    end else begin
      alu_instr = head_s;
      sfu_instr = head_s;
      vec_instr = head_s;
    end
  end

  // Entry storage; a flush discards any same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 40'h0;
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= in_instr;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Illegal retirement record; op and count survive a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_valid_r <= 1'b0;
      illegal_op_r    <= 8'h0;
      illegal_count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      illegal_valid_r <= 1'b0;
    end else begin
      illegal_valid_r <= ill_pop_s;
      if (ill_pop_s) begin
        illegal_op_r    <= head_s[39:32];
        illegal_count_r <= sat_inc(illegal_count_r);
      end
    end
  end

  assign illegal_valid = illegal_valid_r;
  assign illegal_op    = illegal_op_r;
  assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instr_dispatch;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [39:0]       in_instr;
  logic              alu_valid, sfu_valid, vec_valid;
  logic              alu_ready, sfu_ready, vec_ready;
  logic [39:0]       alu_instr, sfu_instr, vec_instr;
  logic              illegal_valid;
  logic [7:0]        illegal_op;
  logic [CNT_W-1:0]  illegal_count;
  logic [OCC_W-1:0]  occupancy;
  logic              idle;

  int tests_run = 0;
  int tests_failed = 0;

  logic [39:0] q[$];
  int          m_cnt = 0;
  logic [7:0]  m_ill_op = 8'h0;
  logic        m_ill_valid = 1'b0;

  instr_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_instr(alu_instr),
    .sfu_valid(sfu_valid), .sfu_ready(sfu_ready), .sfu_instr(sfu_instr),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_instr(vec_instr),
    .illegal_valid(illegal_valid), .illegal_op(illegal_op),
    .illegal_count(illegal_count), .occupancy(occupancy), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = ALU, 1 = SFU, 2 = VEC, 3 = illegal
  function automatic int op_class(input logic [7:0] op);
    if (op inside {[8'd0:8'd9], [8'd15:8'd16]}) return 0;
    if (op inside {[8'd10:8'd14]}) return 1;
    if (op inside {[8'd17:8'd20]}) return 2;
    return 3;
  endfunction

  function automatic logic [39:0] model_head();
    logic [39:0] h;
    h = 40'h0;
    if (q.size() > 0) h = q[0];
    return h;
  endfunction

  function automatic logic model_port_valid(input int cls);
    logic [39:0] h;
    if (q.size() == 0) return 1'b0;
    h = q[0];
    return (op_class(h[39:32]) == cls);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cnt = 0;
    m_ill_op = 8'h0;
    m_ill_valid = 1'b0;
  endfunction

  // Advance the model with the currently driven inputs, then step one clock.
  task automatic tick();
    logic [39:0] h;
    logic        do_push;
    logic        do_pop;
    logic        nxt_ill;
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = 1'b0;
    nxt_ill = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        h = q[0];
        case (op_class(h[39:32]))
          0: do_pop = alu_ready;
          1: do_pop = sfu_ready;
          2: do_pop = vec_ready;
          default: begin
            do_pop = 1'b1;
            nxt_ill = 1'b1;
            m_ill_op = h[39:32];
            if (m_cnt < CMAX) m_cnt++;
          end
        endcase
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_instr);
    end
    m_ill_valid = nxt_ill;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (occupancy !== 3'd0) begin tests_failed++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    tests_run++;
    if ({idle, in_ready} !== 2'b11) begin tests_failed++; $display("FAIL reset_idle_ready: got %b want 11", {idle, in_ready}); end
    tests_run++;
    if ({alu_valid, sfu_valid, vec_valid, illegal_valid} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_valids: got %b want 0000", {alu_valid, sfu_valid, vec_valid, illegal_valid});
    end
    tests_run++;
    if ({alu_instr, sfu_instr, vec_instr} !== 120'h0) begin tests_failed++; $display("FAIL reset_instr: got %h want 0", alu_instr); end
    tests_run++;
    if ({illegal_op, illegal_count} !== 12'h0) begin tests_failed++; $display("FAIL reset_illegal: got %h/%h want 0/0", illegal_op, illegal_count); end
  endtask

  task automatic test_single_alu();
    alu_ready = 1'b1; sfu_ready = 1'b1; vec_ready = 1'b1;
    in_valid = 1'b1; in_instr = {8'd0, 32'h0000_0010};
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (alu_valid !== 1'b1 || alu_instr !== 40'h00_0000_0010) begin
      tests_failed++; $display("FAIL single_alu: got v=%b i=%h want v=1 i=0000000010", alu_valid, alu_instr);
    end
    tick();
    tests_run++;
    if (idle !== 1'b1 || occupancy !== 3'd0) begin
      tests_failed++; $display("FAIL single_drain: got idle=%b occ=%0d want 1/0", idle, occupancy);
    end
  endtask

  task automatic test_in_order();
    logic [7:0] ops [3];
    ops[0] = 8'd17; ops[1] = 8'd0; ops[2] = 8'd10;
    alu_ready = 1'b1; sfu_ready = 1'b1; vec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = {ops[i], 32'h100 + 32'(i)};
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if ({vec_valid, alu_valid, sfu_valid} !== 3'b100 || occupancy !== 3'd3) begin
      tests_failed++; $display("FAIL order_stall: got vas=%b occ=%0d want 100/3", {vec_valid, alu_valid, sfu_valid}, occupancy);
    end
    vec_ready = 1'b1;
    tick();
    tests_run++;
    if (alu_valid !== 1'b1 || alu_instr !== {8'd0, 32'h101}) begin
      tests_failed++; $display("FAIL order_alu: got v=%b i=%h want v=1 i=%h", alu_valid, alu_instr, {8'd0, 32'h101});
    end
    tick();
    tests_run++;
    if (sfu_valid !== 1'b1 || sfu_instr !== {8'd10, 32'h102}) begin
      tests_failed++; $display("FAIL order_sfu: got v=%b i=%h want v=1 i=%h", sfu_valid, sfu_instr, {8'd10, 32'h102});
    end
    tick();
    tests_run++;
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL order_idle: got %b want 1", idle); end
  endtask

  task automatic test_full();
    logic [39:0] fifth;
    alu_ready = 1'b0; sfu_ready = 1'b0; vec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = {(i == 0) ? 8'd1 : 8'($urandom_range(0, 20)), $urandom()};
      tick();
    end
    fifth = {8'd3, 32'hCAFE_0005};
    in_instr = fifth;
    tick();
    tests_run++;
    if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_hold: got occ=%0d rdy=%b want 4/0", occupancy, in_ready);
    end
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    tests_run++;
    if (occupancy !== 3'd3 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL full_no_pushthrough: got occ=%0d rdy=%b want 3/1", occupancy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd4 || q.size() != 4 || q[3] !== fifth) begin
      tests_failed++; $display("FAIL full_fifth_accept: got occ=%0d want 4", occupancy);
    end
    alu_ready = 1'b1; sfu_ready = 1'b1; vec_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL full_drain: got idle=%b want 1", idle); end
  endtask

  task automatic test_illegal();
    alu_ready = 1'b1; sfu_ready = 1'b1; vec_ready = 1'b1;
    in_valid = 1'b1; in_instr = {8'h2A, 32'hDEAD_BEEF};
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({alu_valid, sfu_valid, vec_valid, illegal_valid} !== 4'b0000 || occupancy !== 3'd1) begin
      tests_failed++; $display("FAIL illegal_no_port: got %b occ=%0d want 0000/1", {alu_valid, sfu_valid, vec_valid, illegal_valid}, occupancy);
    end
    tick();
    tests_run++;
    if (illegal_valid !== 1'b1 || illegal_op !== 8'h2A || illegal_count !== 4'd1 || idle !== 1'b1) begin
      tests_failed++; $display("FAIL illegal_retire: got v=%b op=%h cnt=%0d idle=%b want 1/2a/1/1", illegal_valid, illegal_op, illegal_count, idle);
    end
    tick();
    tests_run++;
    if (illegal_valid !== 1'b0) begin tests_failed++; $display("FAIL illegal_pulse: got %b want 0", illegal_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 5; i++) begin
      in_valid = 1'b1; in_instr = {8'($urandom_range(21, 255)), $urandom()};
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (illegal_count !== 4'hF || m_cnt != CMAX) begin
      tests_failed++; $display("FAIL illegal_saturate: got %h want f", illegal_count);
    end
    tests_run++;
    if (illegal_op !== m_ill_op) begin tests_failed++; $display("FAIL illegal_last_op: got %h want %h", illegal_op, m_ill_op); end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] saved;
    saved = illegal_count;
    alu_ready = 1'b0; sfu_ready = 1'b0; vec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = {8'($urandom_range(0, 20)), $urandom()};
      tick();
    end
    flush = 1'b1; in_instr = {8'd2, 32'h5555_AAAA};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 3'd0 || {alu_valid, sfu_valid, vec_valid} !== 3'b000) begin
      tests_failed++; $display("FAIL flush_clear: got occ=%0d v=%b want 0/000", occupancy, {alu_valid, sfu_valid, vec_valid});
    end
    tick();
    tests_run++;
    if (idle !== 1'b1 || illegal_count !== saved) begin
      tests_failed++; $display("FAIL flush_drop_push: got idle=%b cnt=%0d want 1/%0d", idle, illegal_count, saved);
    end
    alu_ready = 1'b1; sfu_ready = 1'b1; vec_ready = 1'b1;
    in_valid = 1'b1; in_instr = {8'h80, 32'h1};
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (illegal_valid !== 1'b0 || illegal_count !== saved || occupancy !== 3'd0) begin
      tests_failed++; $display("FAIL flush_beats_illegal: got v=%b cnt=%0d occ=%0d want 0/%0d/0", illegal_valid, illegal_count, occupancy, saved);
    end
  endtask

  task automatic test_async_reset();
    alu_ready = 1'b0; sfu_ready = 1'b0; vec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = {8'd4, 32'h77 + 32'(i)};
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (occupancy !== 3'd0 || idle !== 1'b1 || alu_valid !== 1'b0 || alu_instr !== 40'h0) begin
      tests_failed++; $display("FAIL async_reset_fifo: got occ=%0d idle=%b v=%b i=%h want 0/1/0/0", occupancy, idle, alu_valid, alu_instr);
    end
    tests_run++;
    if (illegal_count !== 4'd0 || illegal_op !== 8'h0) begin
      tests_failed++; $display("FAIL async_reset_illegal: got cnt=%0d op=%h want 0/00", illegal_count, illegal_op);
    end
    #3 rst_n = 1'b1;
    tick();
    sfu_ready = 1'b1;
    in_valid = 1'b1; in_instr = {8'd12, 32'h0BAD_F00D};
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (sfu_valid !== 1'b1 || sfu_instr !== {8'd12, 32'h0BAD_F00D}) begin
      tests_failed++; $display("FAIL async_reset_resume: got v=%b i=%h want 1/%h", sfu_valid, sfu_instr, {8'd12, 32'h0BAD_F00D});
    end
    tick();
  endtask

  task automatic test_random();
    logic [39:0] eh;
    logic        hold;
    int          errs;
    hold = 1'b0;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = {($urandom_range(0, 7) == 0) ? 8'($urandom_range(21, 255)) : 8'($urandom_range(0, 20)), $urandom()};
      end
      alu_ready = ($urandom_range(0, 2) != 0);
      sfu_ready = ($urandom_range(0, 2) != 0);
      vec_ready = ($urandom_range(0, 1) != 0);
      flush = ($urandom_range(0, 31) == 0);
      hold = in_valid && (q.size() >= DEPTH) && !flush;
      tick();
      flush = 1'b0;
      eh = model_head();
      tests_run++;
      if ({alu_valid, sfu_valid, vec_valid} !== {model_port_valid(0), model_port_valid(1), model_port_valid(2)}) begin
        tests_failed++; $display("FAIL rand_valids c=%0d: got %b want %b", c, {alu_valid, sfu_valid, vec_valid}, {model_port_valid(0), model_port_valid(1), model_port_valid(2)});
      end
      tests_run++;
      if ({alu_instr, sfu_instr, vec_instr} !== {eh, eh, eh}) begin
        tests_failed++; $display("FAIL rand_instr c=%0d: got %h/%h/%h want %h", c, alu_instr, sfu_instr, vec_instr, eh);
      end
      tests_run++;
      if (occupancy !== OCC_W'(q.size()) || idle !== (q.size() == 0) || in_ready !== (q.size() < DEPTH)) begin
        tests_failed++; $display("FAIL rand_status c=%0d: got occ=%0d idle=%b rdy=%b want occ=%0d", c, occupancy, idle, in_ready, q.size());
      end
      tests_run++;
      if (illegal_valid !== m_ill_valid || illegal_op !== m_ill_op || illegal_count !== CNT_W'(m_cnt)) begin
        tests_failed++; $display("FAIL rand_illegal c=%0d: got v=%b op=%h cnt=%0d want v=%b op=%h cnt=%0d", c, illegal_valid, illegal_op, illegal_count, m_ill_valid, m_ill_op, m_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 40'h0;
    alu_ready = 1'b0; sfu_ready = 1'b0; vec_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_alu();
    test_in_order();
    test_full();
    test_illegal();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Consumes the `instruction_t` stream (`op`, 8 b; `dst`, 32 b) produced by decode.
- Buffers instructions in a small in-order FIFO.
- Steers each head instruction to one of three execution ports: scalar ALU, special-function unit (SFU) or vector unit. Opcodes outside `operation_t` are retired as illegal.
- Sits between decode and the execution units.

Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of the saturating illegal-instruction counter.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `flush`  in  1  synchronous; discards all buffered instructions
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  FIFO can accept
- `in_instr`  in  40  `instruction_t`: [39:32] `op`, [31:0] `dst`
- `alu_valid`  out  1  head targets ALU
- `alu_ready`  in  1  ALU accepts
- `alu_instr`  out  40  instruction to ALU
- `sfu_valid`  out  1  head targets SFU
- `sfu_ready`  in  1  SFU accepts
- `sfu_instr`  out  40  instruction to SFU
- `vec_valid`  out  1  head targets vector unit
- `vec_ready`  in  1  vector unit accepts
- `vec_instr`  out  40  instruction to vector unit
- `illegal_valid`  out  1  one-cycle pulse: illegal opcode retired
- `illegal_op`  out  8  opcode of last illegal instruction
- `illegal_count`  out  `CNT_W`  saturating count of illegal instructions
- `occupancy`  out  `$clog2(DEPTH+1)`  entries held
- `idle`  out  1  FIFO empty

Behaviour:
- Reset (`rst_n` low, async):
  - FIFO empty; `occupancy` = 0; `idle` = 1; `in_ready` = 1.
  - All `*_valid` = 0; all `*_instr` = 0.
  - `illegal_valid` = 0; `illegal_op` = 0; `illegal_count` = 0.
- Classification of the head `op`:
  - ALU: 0–9 and 15–16 (`s_add` .. `s_neg`, `s_min`, `s_max`).
  - SFU: 10–14 (`s_sqrt`, `s_exp`, `s_sin`, `s_cos`, `s_tan`).
  - VEC: 17–20 (`v_add` .. `v_div`).
  - Illegal: 21–255.
- Push:
  - Occurs when `in_valid && in_ready`.
  - `in_ready` = `!full`, registered-state based. No push-through when full, even if a pop happens in the same cycle.
- Output ports:
  - Each `*_valid` is combinational from a non-empty FIFO and the head's class; at most one is high per cycle.
  - All three `*_instr` buses carry the head entry whenever non-empty, else 0.
- Latency: an instruction pushed at edge N is visible on its port after edge N (cycle N+1) if the FIFO was empty. Minimum 1 cycle; throughput 1 instruction/cycle.
- Pop:
  - Occurs on `X_valid && X_ready` for the head's class.
  - Strictly in order: a blocked head stalls all younger entries, including those for idle units.
- Illegal head:
  - Popped unconditionally on the next edge without touching any port.
  - On that edge `illegal_valid` is registered high for one cycle and `illegal_op` captures the op.
  - `illegal_count` increments, saturating at all-ones.
- Simultaneous push and pop: allowed when not full; `occupancy` is unchanged.
- Pointers wrap modulo `DEPTH`; `occupancy` never exceeds `DEPTH`.
- Flush:
  - Pointers and `occupancy` clear on the edge; any same-cycle push is dropped; `*_valid` is low the following cycle.
  - Flush has priority over push, pop and illegal retirement; no `illegal_valid` pulse is generated that cycle.
  - `illegal_count` and `illegal_op` are preserved.
- `*_ready` asserted while the matching `*_valid` is low has no effect.
- Upstream must hold `in_instr` stable while `in_valid && !in_ready`.
- Downstream must not depend on `*_ready` to form `*_valid`; no combinational path from `*_ready` to `*_valid` exists.

Test Plan:
- Reset, then push {op=0 (`s_add`), dst=0x0000_0010} with `alu_ready`=1 → cycle+1: `alu_valid`=1, `alu_instr`=0x00_0000_0010; next cycle `idle`=1, `occupancy`=0.
- `vec_ready`=0; push ops 17, 0, 10 → `vec_valid` held, `alu_valid`/`sfu_valid`=0, `occupancy`=3. Raise `vec_ready` → dispatch order vec, alu, sfu on consecutive cycles.
- All readies 0; push 5 instructions → `in_ready` drops after 4, 5th held; `occupancy`=4. Single `alu_ready` pulse with head op=1 → `occupancy` 3, 5th accepted next cycle.
- Push op=0x2A, dst=0xDEAD_BEEF → one-cycle `illegal_valid`, `illegal_op`=0x2A, `illegal_count`=1, no port valid. Force count to 0xFFFF and repeat → stays 0xFFFF.
- FIFO holding 3 entries, assert `flush` together with `in_valid` → next cycle `occupancy`=0, all `*_valid`=0, pushed instruction absent; `illegal_count` unchanged.
- Deassert `rst_n` mid-stream, asynchronously between edges → outputs go to reset values immediately, before the next edge; after release, the FIFO is empty and a new push dispatches normally.
